ahb_apb_bridge_multi: RTL and testbench
=======================================

// Module: ahb_apb_bridge_multi
// PURPOSE
//  AHB-Lite slave to APB master bridge fanning out to NUM_SLV APB peripherals on fixed-size address regions.
//  Registers each AHB address phase, runs the APB SETUP/ACCESS sequence on the decoded peripheral,
//  returns read data / wait states / two-cycle ERROR to AHB. Sits behind the AHB interconnect as the
//  single gateway to all APB devices.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width (32 or 64)
//  NUM_SLV      4   APB peripherals, 1..16
//  REGION_BITS  6   log2 bytes per peripheral region
//  BASE_SLOT    0   region index of peripheral 0 (slot = h_addr[ADDR_W-1:REGION_BITS])
//  TIMEOUT_CYC  16  ACCESS cycles before timeout error (used only with APB_TIMEOUT_EN)
// PORTS
//  h_clk      in   1                clock
//  h_resetn   in   1                async active-low reset
//  h_addr     in   ADDR_W           AHB address
//  h_trans    in   2                IDLE/BUSY/NONSEQ/SEQ
//  h_size     in   3                transfer size
//  h_write    in   1                1 = write
//  h_wdata    in   DATA_W           write data (data phase)
//  h_wstrb    in   DATA_W/8         write strobes (address phase)
//  h_rdata    out  DATA_W           read data
//  h_ready    out  1                transfer done / accept next address
//  h_resp     out  1                1 = ERROR
//  p_addr     out  ADDR_W           APB address (registered)
//  p_sel      out  NUM_SLV          one-hot peripheral select
//  p_enable   out  1                APB ACCESS phase
//  p_write    out  1                APB direction
//  p_wdata    out  DATA_W           = h_wdata
//  p_strb     out  DATA_W/8         registered h_wstrb, forced 0 on reads
//  p_rdata    in   NUM_SLV*DATA_W   per-peripheral read data, peripheral i at [i*DATA_W +: DATA_W]
//  p_ready    in   NUM_SLV          per-peripheral ready
//  p_slverr   in   NUM_SLV          per-peripheral error
// BEHAVIOUR
//  - Reset (async): state IDLE, p_sel=0, p_enable=0, p_addr/p_strb=0, p_write=0, h_resp=0. h_ready=1.
//  - Sample rule: h_ready=1 and h_trans is NONSEQ or SEQ. IDLE/BUSY get a zero-wait OKAY; no APB activity.
//  - Decode (at sample): slot-BASE_SLOT < NUM_SLV -> valid. Otherwise invalid, as is
//    h_size > log2(DATA_W/8). Invalid -> ERR1 with no APB cycle.
//  - FSM:
//    IDLE -> SETUP on valid sample.
//    SETUP: p_sel[i]=1, p_enable=0, h_ready=0. Always -> ACCESS.
//    ACCESS: p_sel[i]=1, p_enable=1.
//      p_ready[i]=0: stay, h_ready=0.
//      p_ready[i]=1, !p_slverr[i]: h_ready=1, h_rdata=p_rdata[i]. Next valid sample -> SETUP, else -> IDLE.
//      p_ready[i]=1, p_slverr[i]: -> ERR1.
//    ERR1: h_ready=0, h_resp=1, p_sel=0, p_enable=0. -> ERR2.
//    ERR2: h_ready=1, h_resp=1. Sample rule applies (master may cancel with IDLE).
//  - Latency: minimum 2 h_clk from address sample to h_ready=1 (one AHB wait state).
//  - h_rdata: 0 except in ACCESS completion of a read.
//  - p_wdata stability: p_wdata tracks h_wdata, which AHB holds stable while h_ready=0.
//  - Reset mid-operation: APB strobes drop immediately; the in-flight transfer is abandoned, no response given.
//  - p_ready/p_slverr from unselected peripherals are ignored.
// CONFIGURATION
//  APB_TIMEOUT_EN defined:
//    - Counter clears on SETUP and increments each ACCESS cycle with p_ready[i]=0.
//    - Reaching TIMEOUT_CYC drops p_sel/p_enable and enters ERR1.
//  Undefined: ACCESS waits indefinitely; no counter logic.
// STRUCTURE
//  - Package ahb_apb_pkg holds:
//    - htrans_t enum (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//    - bridge_state_t enum (IDLE, SETUP, ACCESS, ERR1, ERR2)
//    - RESP_OKAY=0, RESP_ERROR=1
//  - Sub-module ahb_apb_decoder(addr, size -> one-hot sel, valid), parametrised as above.
// TESTING
//  1. Read peripheral 2 (h_addr=0x80): p_ready=1 first ACCESS -> h_ready low 1 cycle, h_rdata=p_rdata[2], h_resp=0.
//  2. Write 0xDEADBEEF to 0x40, h_wstrb=4'b0011, p_ready low 3 cycles:
//     -> p_sel[1] held 5 cycles, p_strb=0011, p_wdata stable, h_ready=1 after ACCESS.
//  3. Access 0x100 with NUM_SLV=4: no p_sel -> h_resp=1 two cycles (h_ready 0 then 1).
//  4. p_slverr=1 with p_ready=1: ERR1 then ERR2; next NONSEQ accepted in ERR2 -> SETUP follows.
//  5. Back-to-back SEQ reads to 0x00/0x04: second address sampled on first completion -> SETUP next cycle, no IDLE gap.
//  6. APB_TIMEOUT_EN, p_ready stuck 0: ERROR after 16 ACCESS cycles. h_resetn pulse mid-ACCESS -> all outputs reset values.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_apb_pkg
//   Shared types and constants for the AHB-Lite to multi-peripheral APB
//   bridge: AHB transfer-type encoding, bridge FSM states, response codes and
//   a helper that gives the largest legal h_size for a data-bus width.
// ----------------------------------------------------------------------------
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // Largest h_size encoding that fits the data bus (2 for 32-bit, 3 for 64-bit).
    function automatic logic [2:0] max_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/ahb_apb_decoder.sv
// ----------------------------------------------------------------------------
// ahb_apb_decoder
//   Maps an AHB address onto one of NUM_SLV fixed-size APB regions.
//   The region slot is addr[ADDR_W-1:REGION_BITS]; peripheral i owns slot
//   BASE_SLOT+i. A transfer is valid only if its slot falls inside the
//   peripheral window and its size fits the data bus.
// Ports
//   addr   in   ADDR_W   AHB address (address phase)
//   size   in   3        AHB transfer size
//   sel    out  NUM_SLV  one-hot peripheral select (all zero when invalid)
//   valid  out  1        address and size are legal
// ----------------------------------------------------------------------------
module ahb_apb_decoder
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int REGION_BITS = 6,
    parameter int BASE_SLOT   = 0
) (
    input  logic [ADDR_W-1:0]  addr,
    input  logic [2:0]         size,
    output logic [NUM_SLV-1:0] sel,
    output logic               valid
);

    localparam int         SLOT_W   = ADDR_W - REGION_BITS;
    localparam logic [2:0] MAX_SIZE = max_size(DATA_W);

    logic [SLOT_W-1:0] slot;
    logic [SLOT_W:0]   idx_ext;
    logic [SLOT_W-1:0] idx;
    logic              in_range;
    logic              unused_low;

    assign slot = addr[ADDR_W-1:REGION_BITS];

    // One extra bit catches slots below BASE_SLOT as a borrow instead of a wrap.
    assign idx_ext  = {1'b0, slot} - (SLOT_W + 1)'(BASE_SLOT);
    assign idx      = idx_ext[SLOT_W-1:0];
    assign in_range = !idx_ext[SLOT_W] && (idx < SLOT_W'(NUM_SLV));
    assign valid    = in_range && (size <= MAX_SIZE);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel[i] = valid && (idx == SLOT_W'(i));
        end
    end

    // Offset bits inside a region do not take part in decoding.
    assign unused_low = ^addr[REGION_BITS-1:0];

endmodule

// File: rtl/ahb_apb_bridge_multi.sv
// ----------------------------------------------------------------------------
// ahb_apb_bridge_multi
//   AHB-Lite slave to APB master bridge fanning out to NUM_SLV peripherals.
//   Each accepted AHB address phase is registered and replayed as an APB
//   SETUP/ACCESS sequence on the decoded peripheral; read data, wait states
//   and the two-cycle ERROR response are returned on the AHB side.
//   Illegal addresses or sizes are answered with ERROR and no APB cycle.
//
// Optional feature
//   APB_TIMEOUT_EN : when defined, an ACCESS phase that sees TIMEOUT_CYC
//                    not-ready cycles is abandoned and answered with ERROR.
//                    When undefined ACCESS waits indefinitely.
//
// Ports
//   h_clk, h_resetn      clock, asynchronous active-low reset
//   h_addr, h_trans,     AHB address phase (h_wstrb sampled with the address)
//   h_size, h_write,
//   h_wstrb
//   h_wdata              AHB write data (data phase), passed straight to p_wdata
//   h_rdata, h_ready,    AHB response
//   h_resp
//   p_addr, p_sel,       APB request (registered)
//   p_enable, p_write,
//   p_strb
//   p_wdata              APB write data (= h_wdata)
//   p_rdata, p_ready,    per-peripheral APB responses, peripheral i at
//   p_slverr             p_rdata[i*DATA_W +: DATA_W] / bit i
// ----------------------------------------------------------------------------
module ahb_apb_bridge_multi
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int REGION_BITS = 6,
    parameter int BASE_SLOT   = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                      h_clk,
    input  logic                      h_resetn,
    input  logic [ADDR_W-1:0]         h_addr,
    input  logic [1:0]                h_trans,
    input  logic [2:0]                h_size,
    input  logic                      h_write,
    input  logic [DATA_W-1:0]         h_wdata,
    input  logic [DATA_W/8-1:0]       h_wstrb,
    output logic [DATA_W-1:0]         h_rdata,
    output logic                      h_ready,
    output logic                      h_resp,
    output logic [ADDR_W-1:0]         p_addr,
    output logic [NUM_SLV-1:0]        p_sel,
    output logic                      p_enable,
    output logic                      p_write,
    output logic [DATA_W-1:0]         p_wdata,
    output logic [DATA_W/8-1:0]       p_strb,
    input  logic [NUM_SLV*DATA_W-1:0] p_rdata,
    input  logic [NUM_SLV-1:0]        p_ready,
    input  logic [NUM_SLV-1:0]        p_slverr
);

    if (NUM_SLV < 1 || NUM_SLV > 16 || (DATA_W != 32 && DATA_W != 64) ||
        TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ahb_apb_bridge_multi: unsupported parameter set");
    end

    bridge_state_t       state;
    logic                sample;
    logic                dec_valid;
    logic [NUM_SLV-1:0]  dec_sel;
    logic                sel_rdy;
    logic                sel_err;
    logic                done;
    logic                timeout_hit;
    logic [DATA_W-1:0]   sel_rdata;

    ahb_apb_decoder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_SLV     (NUM_SLV),
        .REGION_BITS (REGION_BITS),
        .BASE_SLOT   (BASE_SLOT)
    ) u_decoder (
        .addr  (h_addr),
        .size  (h_size),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    // Only the selected peripheral's handshake matters; p_sel is zero outside
    // SETUP/ACCESS so these collapse to 0 there.
    assign sel_rdy = |(p_ready & p_sel);
    assign sel_err = |(p_slverr & p_sel);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | (p_rdata[i*DATA_W +: DATA_W] & {DATA_W{p_sel[i]}});
        end
    end

    assign done   = (state == ST_ACCESS) && sel_rdy && !sel_err;
    assign sample = h_ready && ((h_trans == HT_NONSEQ) || (h_trans == HT_SEQ));

    // AHB response is derived from the registered state plus the live APB
    // handshake, so a ready peripheral completes in the same cycle.
    always_comb begin
        case (state)
            ST_IDLE:   h_ready = 1'b1;
            ST_SETUP:  h_ready = 1'b0;
            ST_ACCESS: h_ready = done;
            ST_ERR1:   h_ready = 1'b0;
            ST_ERR2:   h_ready = 1'b1;
            default:   h_ready = 1'b1;
        endcase
    end

    assign h_resp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
    assign h_rdata = (done && !p_write) ? sel_rdata : '0;
    assign p_wdata = h_wdata;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            to_cnt <= '0;
        end else if (state == ST_SETUP) begin
            to_cnt <= '0;
        end else if ((state == ST_ACCESS) && !sel_rdy) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Fires on the ACCESS cycle that would bring the count to TIMEOUT_CYC.
    assign timeout_hit = (state == ST_ACCESS) && !sel_rdy &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge h_clk or negedge h_resetn) begin
        if (!h_resetn) begin
            state    <= ST_IDLE;
            p_sel    <= '0;
            p_enable <= 1'b0;
            p_addr   <= '0;
            p_strb   <= '0;
            p_write  <= 1'b0;
        end else begin
            case (state)
                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    p_enable <= 1'b1;
                end
                ST_ACCESS: begin
                    if ((sel_rdy && sel_err) || timeout_hit) begin
                        state    <= ST_ERR1;
                        p_sel    <= '0;
                        p_enable <= 1'b0;
                    end else if (sel_rdy) begin
                        state    <= ST_IDLE;
                        p_sel    <= '0;
                        p_enable <= 1'b0;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_IDLE;
            endcase

            // A new address can only be sampled while h_ready is high (IDLE,
            // ERR2, ACCESS completion); it overrides the default move above so
            // back-to-back transfers go straight to SETUP without an IDLE gap.
            if (sample) begin
                if (dec_valid) begin
                    state    <= ST_SETUP;
                    p_sel    <= dec_sel;
                    p_enable <= 1'b0;
                    p_addr   <= h_addr;
                    p_write  <= h_write;
                    p_strb   <= h_write ? h_wstrb : '0;
                end else begin
                    state    <= ST_ERR1;
                    p_sel    <= '0;
                    p_enable <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_multi.sv
// ----------------------------------------------------------------------------
// tb_ahb_apb_bridge_multi
//   Directed bench for ahb_apb_bridge_multi with four 32-bit peripherals.
//   Inputs change on the falling edge; outputs are checked 1 ns later.
// ----------------------------------------------------------------------------
module tb_ahb_apb_bridge_multi;
    import ahb_apb_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 4;
    localparam int STRB_W  = DATA_W / 8;

    logic                      h_clk = 1'b0;
    logic                      h_resetn;
    logic [ADDR_W-1:0]         h_addr;
    logic [1:0]                h_trans;
    logic [2:0]                h_size;
    logic                      h_write;
    logic [DATA_W-1:0]         h_wdata;
    logic [STRB_W-1:0]         h_wstrb;
    logic [DATA_W-1:0]         h_rdata;
    logic                      h_ready;
    logic                      h_resp;
    logic [ADDR_W-1:0]         p_addr;
    logic [NUM_SLV-1:0]        p_sel;
    logic                      p_enable;
    logic                      p_write;
    logic [DATA_W-1:0]         p_wdata;
    logic [STRB_W-1:0]         p_strb;
    logic [NUM_SLV*DATA_W-1:0] p_rdata;
    logic [NUM_SLV-1:0]        p_ready;
    logic [NUM_SLV-1:0]        p_slverr;

    int errors = 0;
    int checks = 0;
    int sel_cycles;
    int acc_cycles;
    logic got_err;

    always #5 h_clk = ~h_clk;

    ahb_apb_bridge_multi #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .NUM_SLV     (NUM_SLV),
        .REGION_BITS (6),
        .BASE_SLOT   (0),
        .TIMEOUT_CYC (16)
    ) dut (
        .h_clk    (h_clk),
        .h_resetn (h_resetn),
        .h_addr   (h_addr),
        .h_trans  (h_trans),
        .h_size   (h_size),
        .h_write  (h_write),
        .h_wdata  (h_wdata),
        .h_wstrb  (h_wstrb),
        .h_rdata  (h_rdata),
        .h_ready  (h_ready),
        .h_resp   (h_resp),
        .p_addr   (p_addr),
        .p_sel    (p_sel),
        .p_enable (p_enable),
        .p_write  (p_write),
        .p_wdata  (p_wdata),
        .p_strb   (p_strb),
        .p_rdata  (p_rdata),
        .p_ready  (p_ready),
        .p_slverr (p_slverr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ahb(input logic [ADDR_W-1:0] a, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [STRB_W-1:0] st);
        h_addr  = a;
        h_trans = tr;
        h_write = wr;
        h_size  = sz;
        h_wstrb = st;
    endtask

    initial begin
        p_rdata  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        p_ready  = '1;
        p_slverr = '0;
        h_wdata  = '0;
        ahb('0, HT_IDLE, 1'b0, 3'd2, '0);
        h_resetn = 1'b0;

        // Reset state
        repeat (2) @(negedge h_clk);
        #1;
        check("rst_ready",  h_ready,  1);
        check("rst_resp",   h_resp,   0);
        check("rst_sel",    p_sel,    0);
        check("rst_enable", p_enable, 0);
        check("rst_addr",   p_addr,   0);
        check("rst_strb",   p_strb,   0);
        check("rst_write",  p_write,  0);
        h_resetn = 1'b1;

        // 1: read peripheral 2, ready on first ACCESS; only its ready is set
        @(negedge h_clk);
        ahb(32'h80, HT_NONSEQ, 1'b0, 3'd2, 4'hF);
        p_ready = 4'b0100;
        #1 check("t1_idle_ready", h_ready, 1);
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        check("t1_setup_sel",   p_sel,    4'b0100);
        check("t1_setup_en",    p_enable, 0);
        check("t1_setup_ready", h_ready,  0);
        check("t1_paddr",       p_addr,   32'h80);
        check("t1_read_strb",   p_strb,   0);
        @(negedge h_clk);
        #1;
        check("t1_acc_en",    p_enable, 1);
        check("t1_acc_ready", h_ready,  1);
        check("t1_rdata",     h_rdata,  32'h3333_3333);
        check("t1_resp",      h_resp,   0);
        @(negedge h_clk);
        #1;
        check("t1_idle_sel",   p_sel,   0);
        check("t1_idle_rdata", h_rdata, 0);

        // 2: write 0xDEADBEEF to peripheral 1 with three not-ready ACCESS cycles;
        //    other peripherals report ready and must be ignored
        @(negedge h_clk);
        ahb(32'h40, HT_NONSEQ, 1'b1, 3'd2, 4'b0011);
        p_ready = 4'b1101;
        #1;
        @(negedge h_clk);
        h_trans = HT_IDLE;
        h_wdata = 32'hDEAD_BEEF;
        h_wstrb = 4'hF;
        sel_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge h_clk);
            if (k == 4) p_ready = 4'b1111;
            #1;
            if (p_sel[1]) sel_cycles++;
            check("t2_strb",   p_strb,   4'b0011);
            check("t2_wdata",  p_wdata,  32'hDEAD_BEEF);
            check("t2_enable", p_enable, (k != 0));
            check("t2_ready",  h_ready,  (k == 4));
        end
        check("t2_write",  p_write, 1);
        check("t2_rdata",  h_rdata, 0);
        @(negedge h_clk);
        #1;
        check("t2_sel_cycles", sel_cycles, 5);
        check("t2_idle_sel",   p_sel,      0);

        // 3: out-of-range address, then oversize transfer -> two-cycle ERROR
        @(negedge h_clk);
        ahb(32'h100, HT_NONSEQ, 1'b0, 3'd2, 4'hF);
        #1 check("t3_accept_ready", h_ready, 1);
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        check("t3_err1_ready", h_ready, 0);
        check("t3_err1_resp",  h_resp,  1);
        check("t3_err1_sel",   p_sel,   0);
        @(negedge h_clk);
        #1;
        check("t3_err2_ready", h_ready, 1);
        check("t3_err2_resp",  h_resp,  1);
        check("t3_err2_sel",   p_sel,   0);
        @(negedge h_clk);
        #1 check("t3_idle_resp", h_resp, 0);
        @(negedge h_clk);
        ahb(32'h00, HT_NONSEQ, 1'b0, 3'd3, 4'hF);
        #1;
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        check("t3_size_resp", h_resp, 1);
        check("t3_size_sel",  p_sel,  0);
        repeat (2) @(negedge h_clk);
        #1 check("t3_size_idle", h_resp, 0);

        // 4: slave error, then new NONSEQ accepted during ERR2
        @(negedge h_clk);
        ahb(32'h00, HT_NONSEQ, 1'b0, 3'd2, 4'hF);
        p_ready  = '1;
        p_slverr = 4'b0001;
        #1;
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        @(negedge h_clk);
        #1;
        check("t4_acc_ready", h_ready, 0);
        check("t4_acc_resp",  h_resp,  0);
        check("t4_acc_rdata", h_rdata, 0);
        @(negedge h_clk);
        #1;
        check("t4_err1_resp",  h_resp,   1);
        check("t4_err1_ready", h_ready,  0);
        check("t4_err1_en",    p_enable, 0);
        @(negedge h_clk);
        p_slverr = '0;
        ahb(32'hC0, HT_NONSEQ, 1'b0, 3'd2, 4'hF);
        #1;
        check("t4_err2_resp",  h_resp,  1);
        check("t4_err2_ready", h_ready, 1);
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        check("t4_setup_sel",  p_sel,    4'b1000);
        check("t4_setup_en",   p_enable, 0);
        check("t4_setup_addr", p_addr,   32'hC0);
        check("t4_setup_resp", h_resp,   0);
        @(negedge h_clk);
        #1 check("t4_rdata", h_rdata, 32'h4444_4444);

        // 5: back-to-back reads 0x00 then SEQ 0x04, no IDLE gap
        @(negedge h_clk);
        ahb(32'h00, HT_NONSEQ, 1'b0, 3'd2, 4'hF);
        #1;
        @(negedge h_clk);
        ahb(32'h04, HT_SEQ, 1'b0, 3'd2, 4'hF);
        #1 check("t5_setup_ready", h_ready, 0);
        @(negedge h_clk);
        #1;
        check("t5_first_ready", h_ready, 1);
        check("t5_first_rdata", h_rdata, 32'h1111_1111);
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        check("t5_setup2_en",   p_enable, 0);
        check("t5_setup2_sel",  p_sel,    4'b0001);
        check("t5_setup2_addr", p_addr,   32'h04);
        check("t5_setup2_rdy",  h_ready,  0);
        @(negedge h_clk);
        #1;
        check("t5_second_ready", h_ready, 1);
        check("t5_second_rdata", h_rdata, 32'h1111_1111);

`ifdef APB_TIMEOUT_EN
        // Timeout: peripheral never ready -> ERROR after 16 ACCESS cycles
        @(negedge h_clk);
        ahb(32'h80, HT_NONSEQ, 1'b0, 3'd2, 4'hF);
        p_ready = '0;
        #1;
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        acc_cycles = 0;
        got_err    = 1'b0;
        for (int k = 0; k < 40 && !got_err; k++) begin
            @(negedge h_clk);
            #1;
            if (h_resp) got_err = 1'b1;
            else if (p_enable) acc_cycles++;
        end
        check("to_error_seen", got_err,    1);
        check("to_acc_cycles", acc_cycles, 16);
        check("to_sel_drop",   p_sel,      0);
        p_ready = '1;
        repeat (2) @(negedge h_clk);
`endif

        // 6: reset pulse in the middle of a stalled write ACCESS
        @(negedge h_clk);
        ahb(32'h40, HT_NONSEQ, 1'b1, 3'd2, 4'b1010);
        p_ready = '0;
        #1;
        @(negedge h_clk);
        h_trans = HT_IDLE;
        #1;
        @(negedge h_clk);
        #1;
        check("t6_stall_en",    p_enable, 1);
        check("t6_stall_ready", h_ready,  0);
        h_resetn = 1'b0;
        #1;
        check("t6_rst_sel",   p_sel,    0);
        check("t6_rst_en",    p_enable, 0);
        check("t6_rst_addr",  p_addr,   0);
        check("t6_rst_strb",  p_strb,   0);
        check("t6_rst_write", p_write,  0);
        check("t6_rst_ready", h_ready,  1);
        check("t6_rst_resp",  h_resp,   0);
        @(negedge h_clk);
        h_resetn = 1'b1;
        p_ready  = '1;
        @(negedge h_clk);
        #1;
        check("t6_after_sel",   p_sel,   0);
        check("t6_after_ready", h_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
